// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: shares one 8N1 UART transmit line among N_REQ message
// sources. Round-robin grant held for a whole message, inter-character and
// inter-message pauses, direct drive of tx.
// Optional feature macro: UART_ARB_TIMEOUT_EN (drops a stalled message after
// TIMEOUT idle cycles in LOAD and pulses abort).
module uart_msg_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 5208,
  parameter int CHAR_GAP     = 1000,
  parameter int MSG_GAP      = 5000,
  parameter int TIMEOUT      = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               tx,
  output logic               abort
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int PW      = $clog2(N_REQ);
  localparam int BW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_MAX = (CHAR_GAP > MSG_GAP) ? CHAR_GAP : MSG_GAP;
  localparam int CNT_MAX = (GAP_MAX > TIMEOUT) ? GAP_MAX : TIMEOUT;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned NU = N_REQ;

  localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CG_LAST  = CW'((CHAR_GAP > 0) ? CHAR_GAP - 1 : 0);
  localparam logic [CW-1:0] MG_LAST  = CW'((MSG_GAP > 0) ? MSG_GAP - 1 : 0);
`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
`endif

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [BW-1:0] bcnt;
  logic [2:0]    bidx;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic          last_q;
  logic          gap_msg;
  logic [PW-1:0] pick;
  logic          pick_ok;
  logic          abort_q;

  // Round-robin search: first valid requester starting after the last owner.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    pick    = ptr;
    pick_ok = 1'b0;
    for (int unsigned off = 1; off <= NU; off++) begin
      idx = (32'(ptr) + off) % NU;
      if (!pick_ok && req_valid[PW'(idx)]) begin
        pick    = PW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  // Control FSM, bit timing, serializer and gap/timeout counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= PTR_RST;
      grant   <= '0;
      tx      <= 1'b1;
      abort_q <= 1'b0;
      bcnt    <= '0;
      bidx    <= '0;
      cnt     <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      gap_msg <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (pick_ok) begin
            grant <= N_REQ'(1) << pick;
            ptr   <= pick;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (req_valid[ptr]) begin
            shreg  <= req_data[{ptr, 3'b000} +: 8];
            last_q <= req_last[ptr];
            tx     <= 1'b0;
            bcnt   <= '0;
            cnt    <= '0;
            state  <= S_START;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            abort_q <= 1'b1;
            grant   <= '0;
            cnt     <= '0;
            gap_msg <= 1'b1;
            state   <= (MSG_GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_START: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            bidx  <= '0;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
            state <= S_DATA;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        S_DATA: begin
          if (bcnt == BIT_LAST) begin
            bcnt <= '0;
            if (bidx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
              bidx  <= bidx + 3'd1;
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        S_STOP: begin
          if (bcnt == BIT_LAST) begin
            bcnt <= '0;
            cnt  <= '0;
            if (last_q) begin
              grant   <= '0;
              gap_msg <= 1'b1;
              state   <= (MSG_GAP == 0) ? S_IDLE : S_GAP;
            end else begin
              gap_msg <= 1'b0;
              state   <= (CHAR_GAP == 0) ? S_LOAD : S_GAP;
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        S_GAP: begin
          if (cnt == (gap_msg ? MG_LAST : CG_LAST)) begin
            cnt   <= '0;
            state <= gap_msg ? S_IDLE : S_LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign req_ready = (state == S_LOAD) ? grant : '0;

`ifdef UART_ARB_TIMEOUT_EN
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: requester queues drive the DUTs,
// expected bytes/owners are queued by each test and compared by a UART frame
// monitor. dut uses the nominal gaps, dut_zg uses zero gaps.
module tb_uart_msg_arbiter;

  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] gnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  valid [2];
  logic [3:0]  last  [2];
  logic [31:0] data  [2];
  logic [3:0]  ready [2];
  logic [3:0]  gnt   [2];
  logic        busy  [2];
  logic        tx_w  [2];
  logic        abort [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int oh_bad = 0;
  int rdy_bad = 0;
  int abort_cnt [2];

  logic [8:0] rq [8][$];
  bit         took [8];
  exp_t       exp_q [2][$];
  int         starts [2][$];

  bit         m_act  [2];
  int         m_t    [2];
  logic [9:0] m_bits [2];
  logic [3:0] m_gnt  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_msg_arbiter #(.N_REQ(4), .CLKS_PER_BIT(CPB), .CHAR_GAP(2), .MSG_GAP(5), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .req_valid(valid[0]), .req_data(data[0]), .req_last(last[0]),
    .req_ready(ready[0]), .grant(gnt[0]), .busy(busy[0]), .tx(tx_w[0]), .abort(abort[0]));

  uart_msg_arbiter #(.N_REQ(4), .CLKS_PER_BIT(CPB), .CHAR_GAP(0), .MSG_GAP(0), .TIMEOUT(20)) dut_zg (
    .clk(clk), .reset(reset), .req_valid(valid[1]), .req_data(data[1]), .req_last(last[1]),
    .req_ready(ready[1]), .grant(gnt[1]), .busy(busy[1]), .tx(tx_w[1]), .abort(abort[1]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic offer(input int k, input logic lst, input logic [7:0] b);
    rq[k].push_back({lst, b});
  endtask

  task automatic expect_byte(input int d, input logic [7:0] b, input logic [3:0] g);
    exp_t e;
    e.data = b;
    e.gnt  = g;
    exp_q[d].push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) rq[k].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      starts[d].delete();
      exp_q[d].delete();
    end
  endtask

  task automatic wait_drain(input int d, input int budget);
    int t0;
    t0 = cyc;
    while (exp_q[d].size() != 0 && (cyc - t0) < budget) @(negedge clk);
    check_eq("drain", exp_q[d].size(), 0);
    exp_q[d].delete();
  endtask

  task automatic wait_starts(input int d, input int n, input int budget, output int s);
    int t0;
    t0 = cyc;
    while (starts[d].size() < n && (cyc - t0) < budget) @(negedge clk);
    check_eq("start_seen", starts[d].size() >= n, 1);
    s = (starts[d].size() > 0) ? starts[d][starts[d].size() - 1] : cyc;
  endtask

  // Requester models: present queued bytes, pop once a handshake has happened.
  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0;
      last[d]  = '0;
      data[d]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          int k;
          k = d * 4 + i;
          if (took[k]) begin
            if (rq[k].size() > 0) void'(rq[k].pop_front());
            took[k] = 1'b0;
          end
          if (rq[k].size() > 0) begin
            valid[d][i]        = 1'b1;
            data[d][8*i +: 8]  = rq[k][0][7:0];
            last[d][i]         = rq[k][0][8];
          end else begin
            valid[d][i] = 1'b0;
            last[d][i]  = 1'b0;
          end
          took[k] = valid[d][i] && ready[d][i];
        end
      end
    end
  end

  // Frame monitor and always-on protocol checks.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ($countones(gnt[d]) > 1) oh_bad++;
      if ((ready[d] & ~gnt[d]) != 4'd0) rdy_bad++;
      if (abort[d] === 1'b1) abort_cnt[d]++;
      if (reset) begin
        m_act[d] = 1'b0;
      end else begin
        if (!m_act[d] && tx_w[d] === 1'b0) begin
          m_act[d] = 1'b1;
          m_t[d]   = 0;
          m_gnt[d] = gnt[d];
          starts[d].push_back(cyc);
        end
        if (m_act[d]) begin
          if (m_t[d] % CPB == CPB / 2) m_bits[d][m_t[d] / CPB] = tx_w[d];
          if (m_t[d] == 9 * CPB + CPB / 2) begin
            exp_t e;
            check_eq("frame_expected", exp_q[d].size() > 0, 1);
            if (exp_q[d].size() > 0) begin
              e = exp_q[d].pop_front();
              check_eq("start_bit", m_bits[d][0], 1'b0);
              check_eq("stop_bit", m_bits[d][9], 1'b1);
              check_eq("byte", m_bits[d][8:1], e.data);
              check_eq("grant_at_start", m_gnt[d], e.gnt);
              check_eq("grant_at_stop", gnt[d], e.gnt);
            end
          end
          m_t[d]++;
          if (m_t[d] == 10 * CPB) m_act[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    int s, s2;
    abort_cnt[0] = 0;
    abort_cnt[1] = 0;
    do_reset();
    check_eq("rst_tx", tx_w[0], 1'b1);
    check_eq("rst_grant", gnt[0], 4'b0000);
    check_eq("rst_ready", ready[0], 4'b0000);
    check_eq("rst_busy", busy[0], 1'b0);
    check_eq("rst_abort", abort[0], 1'b0);

    // single two-byte message from requester 1
    offer(1, 1'b0, 8'h48);
    offer(1, 1'b1, 8'h0A);
    expect_byte(0, 8'h48, 4'b0010);
    expect_byte(0, 8'h0A, 4'b0010);
    wait_starts(0, 2, 400, s2);
    wait_drain(0, 400);
    check_eq("byte_period", (starts[0].size() == 2) ? starts[0][1] - starts[0][0] : 0, 43);
    wait_cyc(s2 + 39);
    check_eq("grant_end_stop", gnt[0], 4'b0010);
    wait_cyc(s2 + 40);
    check_eq("grant_released", gnt[0], 4'b0000);

    // round robin between requesters 0 and 2
    do_reset();
    offer(0, 1'b1, 8'hA0);
    offer(0, 1'b1, 8'hA1);
    offer(2, 1'b1, 8'hC0);
    offer(2, 1'b1, 8'hC1);
    expect_byte(0, 8'hA0, 4'b0001);
    expect_byte(0, 8'hC0, 4'b0100);
    expect_byte(0, 8'hA1, 4'b0001);
    expect_byte(0, 8'hC1, 4'b0100);
    wait_drain(0, 1000);
    check_eq("msg_spacing", (starts[0].size() >= 2) ? (starts[0][1] - starts[0][0] >= 47) : 0, 1);

    // message lock: requester 3 arrives mid-message of requester 0
    do_reset();
    offer(0, 1'b0, 8'h31);
    offer(0, 1'b0, 8'h32);
    offer(0, 1'b1, 8'h33);
    for (int i = 0; i < 3; i++) expect_byte(0, 8'h31 + 8'(i), 4'b0001);
    wait_starts(0, 1, 200, s);
    offer(3, 1'b1, 8'hD4);
    expect_byte(0, 8'hD4, 4'b1000);
    wait_drain(0, 1000);

    // stall after a non-last byte
    do_reset();
    abort_cnt[0] = 0;
    offer(2, 1'b0, 8'h5A);
    expect_byte(0, 8'h5A, 4'b0100);
    wait_starts(0, 1, 200, s);
`ifdef UART_ARB_TIMEOUT_EN
    wait_cyc(s + 61);
    check_eq("grant_before_abort", gnt[0], 4'b0100);
    while (abort[0] !== 1'b1 && cyc < s + 100) @(negedge clk);
    check_eq("abort_time", cyc - s, 62);
    check_eq("abort_grant", gnt[0], 4'b0000);
    @(negedge clk);
    check_eq("abort_width", abort[0], 1'b0);
    wait_cyc(s + 66);
    check_eq("abort_gap_busy", busy[0], 1'b1);
    wait_cyc(s + 67);
    check_eq("abort_idle", busy[0], 1'b0);
    check_eq("abort_count", abort_cnt[0], 1);
`else
    wait_cyc(s + 100);
    check_eq("stall_busy", busy[0], 1'b1);
    check_eq("stall_grant", gnt[0], 4'b0100);
    check_eq("stall_abort", abort_cnt[0], 0);
`endif
    check_eq("stall_frame", exp_q[0].size(), 0);

    // reset during data bit 2 (frame bit 3)
    do_reset();
    offer(1, 1'b1, 8'hFF);
    wait_starts(0, 1, 200, s);
    wait_cyc(s + 13);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midreset_tx", tx_w[0], 1'b1);
    check_eq("midreset_grant", gnt[0], 4'b0000);
    check_eq("midreset_busy", busy[0], 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(i, 1'b1, 8'h10 + 8'(i));
      expect_byte(0, 8'h10 + 8'(i), 4'(1 << i));
    end
    wait_drain(0, 1000);

    // zero gaps on the second instance
    do_reset();
    offer(4, 1'b0, 8'h11);
    offer(4, 1'b1, 8'h22);
    offer(5, 1'b1, 8'h33);
    expect_byte(1, 8'h11, 4'b0001);
    expect_byte(1, 8'h22, 4'b0001);
    expect_byte(1, 8'h33, 4'b0010);
    wait_drain(1, 600);
    check_eq("zg_starts", starts[1].size(), 3);
    check_eq("zg_byte_period", (starts[1].size() >= 2) ? starts[1][1] - starts[1][0] : 0, 41);
    check_eq("zg_msg_period", (starts[1].size() >= 3) ? starts[1][2] - starts[1][1] : 0, 42);

    check_eq("onehot_grant", oh_bad, 0);
    check_eq("ready_subset", rdy_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_msg_arbiter.md
# uart_msg_arbiter

Shares one 8N1 UART transmit line (HC-05 RXD) among several message sources: sensor alarm reporter, periodic status reporter, and debug. Each source offers a byte stream with a last-byte marker. The block grants the line round-robin, holds the grant for a whole message, and serializes each byte. It inserts inter-character and inter-message pauses and drives `tx` directly.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 5208: clock cycles per UART bit (9600 baud at 50 MHz).
- `CHAR_GAP`, 1000: idle cycles after a non-last byte; 0 is legal.
- `MSG_GAP`, 5000: idle cycles after a last byte, with grant released; 0 is legal.
- `TIMEOUT`, 1_000_000: stall limit while waiting for the next byte of a granted message.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: requester i has a byte on its data lane.
- `req_data` in 8*N_REQ: byte for requester i in bits [8i+7:8i].
- `req_last` in N_REQ: the offered byte is the last byte of its message.
- `req_ready` out N_REQ: transfer strobe for requester i.
- `grant` out N_REQ: one-hot current owner; all zero when none.
- `busy` out 1: high in every state except IDLE.
- `tx` out 1: serial line; idles high.
- `abort` out 1: one-cycle pulse when a granted message is dropped on timeout.

## Operation
- States are IDLE, LOAD, START, DATA, STOP, GAP.
- IDLE:
  - If any `req_valid` bit is set, select the first set bit searching from (ptr+1) mod N_REQ upward.
  - Register the selection into `grant`, set ptr to the winner, and go to LOAD.
  - The decision uses the cycle's `req_valid` only. A valid dropped afterwards does not revoke the grant.
- LOAD:
  - `req_ready` = `grant` (combinational) while in LOAD.
  - A transfer occurs on any cycle where `req_valid[g]` is high. On that cycle, capture `req_data` lane g and `req_last[g]`, then go to START.
  - The requester holds data and last stable while valid is high and not yet accepted.
- START / DATA / STOP:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles. The frame is 10*CLKS_PER_BIT cycles.
  - `grant` is held throughout the frame.
- After STOP, with a non-last byte:
  - Go to GAP for CHAR_GAP cycles with `grant` held, then go to LOAD.
  - If CHAR_GAP = 0, go directly to LOAD.
- After STOP, with a last byte:
  - Clear `grant` on the transition.
  - Go to GAP for MSG_GAP cycles, then go to IDLE.
  - If MSG_GAP = 0, go directly to IDLE.
- Arithmetic:
  - Bit counter width is clog2(CLKS_PER_BIT).
  - Gap and timeout counter width is clog2(max(CHAR_GAP, MSG_GAP, TIMEOUT)+1).
  - The ptr index wraps modulo N_REQ.

## Timing
- Reset values: `tx`=1, `grant`=0, `req_ready`=0, `busy`=0, `abort`=0, state IDLE, ptr = N_REQ-1 (requester 0 wins first), all counters 0.
- Reset mid-frame: `tx` is high from the next edge and the partial byte is lost. No `abort` pulse is generated.
- Latency from IDLE:
  - A `req_valid` seen at edge k gives `grant` at k+1 and a transfer possible at k+1.
  - `tx` goes low at the edge following the transfer.
- Byte-to-byte period inside one message, with valid always high: 10*CLKS_PER_BIT + CHAR_GAP + 1 cycles.
- Message-to-next-message on the line: at least 10*CLKS_PER_BIT + MSG_GAP + 2 cycles from the last byte's start bit to the next start bit.
- `req_ready` never asserts for a non-granted requester, and never outside LOAD.
- A requester's valid rising while another requester owns the line waits. It is considered only in IDLE.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - In LOAD, a counter increments each cycle `req_valid[g]` is low and clears on transfer.
  - When the counter reaches TIMEOUT: pulse `abort` for 1 cycle, clear `grant`, and go to GAP for MSG_GAP cycles.
  - The partial message is not terminated on the line.
- Not defined: no counter exists, `abort` is tied 0, and LOAD waits indefinitely.

## Test plan
Bench parameters: N_REQ=4, CLKS_PER_BIT=4, CHAR_GAP=2, MSG_GAP=5, TIMEOUT=20.
- Single message:
  - Stimulus: requester 1 sends 0x48, 0x0A (last).
  - Required: `tx` frames are 0,0,0,0,1,0,0,1,0,1 then 0,0,1,0,1,0,0,0,0,1, each bit 4 cycles.
  - Required: start bits 43 cycles apart; `grant`=4'b0010 until the second stop ends.
- Round-robin:
  - Stimulus: requesters 0 and 2 both offer 1-byte messages continuously.
  - Required: grant order 0,2,0,2; never two grants high at once.
- Message lock:
  - Stimulus: requester 3 raises valid mid-message of requester 0 (3-byte message).
  - Required: all 3 bytes of requester 0 go out before `grant`=4'b1000.
- Timeout (macro on):
  - Stimulus: requester 2 sends a non-last byte, then drops valid.
  - Required: `abort` pulses exactly 20 cycles after LOAD entry; `grant`=0; IDLE after 5 more cycles.
  - Required with macro off: stays in LOAD; `abort` stays 0.
- Reset mid-DATA:
  - Stimulus: assert `reset` for 1 cycle during bit 3.
  - Required: `tx`=1, `grant`=0, `busy`=0 next edge.
  - Required: the next arbitration with all valid goes to requester 0.
- Zero gaps:
  - Stimulus: CHAR_GAP=0, MSG_GAP=0.
  - Required: byte period of 41 cycles; back-to-back messages have the next start bit 2 cycles after the stop bit ends.
